// File: rtl/steel_machine_timer_pkg.sv
// Shared register offsets, reset constants and byte-lane helpers for the
// Steel machine timer.
package steel_machine_timer_pkg;

  typedef logic [63:0] mtime_t;

  localparam logic [2:0] MTIMER_MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIMER_MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMER_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMER_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] MTIMER_MSIP        = 3'd4;

  localparam mtime_t MTIMER_CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Lane i of the result comes from new_word when mask[i] is set, else from old_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  mask);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/steel_machine_timer_tick_prescaler.sv
// Free-running divider: TICK is high for one cycle out of every TICK_DIV.
// TICK_DIV must lie in 1..65535; with 1 the tick is permanently asserted.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic CLK,
  input  logic RESET,
  output logic TICK
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign TICK = (cnt_q == LAST);

  always_comb begin
    cnt_d = TICK ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/steel_machine_timer.sv
// Memory-mapped mtime/mtimecmp/msip block beside Steel Core's data port.
// Reads return one cycle after the address; writes are byte-masked.
module steel_machine_timer
  import steel_machine_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ADDR,
  input  logic [31:0] WR_DATA,
  input  logic        WR_REQ,
  input  logic [3:0]  WR_MASK,
  output logic [31:0] RD_DATA,
  output logic [63:0] REAL_TIME,
  output logic        T_IRQ,
  output logic        S_IRQ
);

  mtime_t      mtime_q, mtime_d;
  mtime_t      mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        t_irq_q;

  logic        sel;
  logic [2:0]  off;
  logic        wr_en;
  logic        tick;
  logic [31:0] rd_word;
  logic        unused_addr_bits;

  assign sel   = (ADDR[31:5] == BASE_ADDR[31:5]);
  assign off   = ADDR[4:2];
  assign wr_en = sel & WR_REQ & (|WR_MASK);

  // Byte lane within a word carries no meaning for this word-only register file.
  assign unused_addr_bits = ^ADDR[1:0];

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .CLK  (CLK),
    .RESET(RESET),
    .TICK (tick)
  );

  always_comb begin
    rd_word = 32'd0;
    case (off)
      MTIMER_MTIME_LO:    rd_word = mtime_q[31:0];
      MTIMER_MTIME_HI:    rd_word = mtime_q[63:32];
      MTIMER_MTIMECMP_LO: rd_word = mtimecmp_q[31:0];
      MTIMER_MTIMECMP_HI: rd_word = mtimecmp_q[63:32];
      MTIMER_MSIP:        rd_word = {31'd0, msip_q};
      default:            rd_word = 32'd0;
    endcase
    rd_data_d = sel ? rd_word : 32'd0;
  end

  // A software write to either mtime half wins over the tick for that cycle.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_en && off == MTIMER_MTIME_LO) begin
      mtime_d[31:0] = byte_merge(mtime_q[31:0], WR_DATA, WR_MASK);
    end else if (wr_en && off == MTIMER_MTIME_HI) begin
      mtime_d[63:32] = byte_merge(mtime_q[63:32], WR_DATA, WR_MASK);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr_en && off == MTIMER_MTIMECMP_LO) begin
      mtimecmp_d[31:0] = byte_merge(mtimecmp_q[31:0], WR_DATA, WR_MASK);
    end else if (wr_en && off == MTIMER_MTIMECMP_HI) begin
      mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], WR_DATA, WR_MASK);
    end
  end

  always_comb begin
    msip_d = msip_q;
    if (wr_en && off == MTIMER_MSIP && WR_MASK[0]) msip_d = WR_DATA[0];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= MTIMER_CMP_RESET;
      msip_q     <= 1'b0;
      rd_data_q  <= 32'd0;
      t_irq_q    <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rd_data_q  <= rd_data_d;
      t_irq_q    <= (mtime_q >= mtimecmp_q);
    end
  end

  assign RD_DATA   = rd_data_q;
  assign REAL_TIME = mtime_q;
  assign T_IRQ     = t_irq_q;
  assign S_IRQ     = msip_q;

endmodule

// File: tb/tb_steel_machine_timer.sv
// Directed bench for steel_machine_timer: two instances (TICK_DIV 1 and 4)
// share one bus and are checked every cycle against a behavioural model.
module tb_steel_machine_timer;

  localparam logic [31:0] BASE = 32'h0001_0000;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] ADDR = 32'd0;
  logic [31:0] WR_DATA = 32'd0;
  logic        WR_REQ = 1'b0;
  logic [3:0]  WR_MASK = 4'd0;

  logic [31:0] rd[2];
  logic [63:0] rt[2];
  logic        ti[2];
  logic        si[2];

  always #5 CLK = ~CLK;

  steel_machine_timer #(.BASE_ADDR(BASE), .TICK_DIV(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .WR_DATA(WR_DATA), .WR_REQ(WR_REQ),
    .WR_MASK(WR_MASK), .RD_DATA(rd[0]), .REAL_TIME(rt[0]), .T_IRQ(ti[0]), .S_IRQ(si[0])
  );

  steel_machine_timer #(.BASE_ADDR(BASE), .TICK_DIV(4)) u_dut4 (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .WR_DATA(WR_DATA), .WR_REQ(WR_REQ),
    .WR_MASK(WR_MASK), .RD_DATA(rd[1]), .REAL_TIME(rt[1]), .T_IRQ(ti[1]), .S_IRQ(si[1])
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic run_cmp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          div[2] = '{1, 4};
  logic [63:0] m_time[2];
  logic [63:0] m_cmp[2];
  logic        m_sip[2];
  logic [31:0] m_rd[2];
  logic        m_tirq[2];
  int          m_cnt[2];
  logic        m_sel;
  logic [2:0]  m_off;
  logic        m_wr;
  logic        m_tick;

  function automatic logic [31:0] put_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] word_of(input int k, input logic [2:0] o);
    case (o)
      3'd0:    return m_time[k][31:0];
      3'd1:    return m_time[k][63:32];
      3'd2:    return m_cmp[k][31:0];
      3'd3:    return m_cmp[k][63:32];
      3'd4:    return {31'd0, m_sip[k]};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < 2; k++) begin
        m_time[k] = 64'd0;
        m_cmp[k]  = 64'hFFFF_FFFF_FFFF_FFFF;
        m_sip[k]  = 1'b0;
        m_rd[k]   = 32'd0;
        m_tirq[k] = 1'b0;
        m_cnt[k]  = 0;
      end
    end else begin
      m_sel = (ADDR[31:5] == BASE[31:5]);
      m_off = ADDR[4:2];
      m_wr  = m_sel && WR_REQ && (WR_MASK != 4'd0);
      for (int k = 0; k < 2; k++) begin
        m_rd[k]   = m_sel ? word_of(k, m_off) : 32'd0;
        m_tirq[k] = (m_time[k] >= m_cmp[k]);
        m_tick    = (m_cnt[k] == div[k] - 1);
        m_cnt[k]  = m_tick ? 0 : m_cnt[k] + 1;
        if (m_wr && m_off == 3'd0)
          m_time[k][31:0] = put_bytes(m_time[k][31:0], WR_DATA, WR_MASK);
        else if (m_wr && m_off == 3'd1)
          m_time[k][63:32] = put_bytes(m_time[k][63:32], WR_DATA, WR_MASK);
        else if (m_tick)
          m_time[k] = m_time[k] + 64'd1;
        if (m_wr && m_off == 3'd2) m_cmp[k][31:0]  = put_bytes(m_cmp[k][31:0], WR_DATA, WR_MASK);
        if (m_wr && m_off == 3'd3) m_cmp[k][63:32] = put_bytes(m_cmp[k][63:32], WR_DATA, WR_MASK);
        if (m_wr && m_off == 3'd4 && WR_MASK[0]) m_sip[k] = WR_DATA[0];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (run_cmp) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("real_time[%0d]", k), rt[k], m_time[k]);
        chk($sformatf("rd_data[%0d]", k), {32'd0, rd[k]}, {32'd0, m_rd[k]});
        chk($sformatf("t_irq[%0d]", k), {63'd0, ti[k]}, {63'd0, m_tirq[k]});
        chk($sformatf("s_irq[%0d]", k), {63'd0, si[k]}, {63'd0, m_sip[k]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; inputs are held for the next rising edge
  // and the task returns at the following falling edge.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic req,
                     input logic [3:0] m);
    #1;
    ADDR = a; WR_DATA = d; WR_REQ = req; WR_MASK = m;
    @(negedge CLK);
  endtask

  task automatic wr(input logic [2:0] o, input logic [31:0] d, input logic [3:0] m);
    cyc(BASE + {27'd0, o, 2'b00}, d, 1'b1, m);
  endtask

  task automatic rd_off(input logic [2:0] o);
    cyc(BASE + {27'd0, o, 2'b00}, 32'd0, 1'b0, 4'd0);
  endtask

  task automatic idle();
    cyc(32'd0, 32'd0, 1'b0, 4'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge CLK);
    run_cmp = 1'b1;
    chk("reset real_time", rt[0], 64'd0);
    chk("reset t_irq", {63'd0, ti[0]}, 64'd0);
    chk("reset s_irq", {63'd0, si[0]}, 64'd0);
    chk("reset rd_data", {32'd0, rd[0]}, 64'd0);
    #1 RESET = 1'b0;

    // Compare register reset values
    rd_off(3'd2);
    chk("cmp_lo reset read", {32'd0, rd[0]}, 64'hFFFF_FFFF);
    rd_off(3'd3);
    chk("cmp_hi reset read", {32'd0, rd[1]}, 64'hFFFF_FFFF);

    // Byte mask; same-cycle read returns the pre-write word
    wr(3'd2, 32'hAABB_CCDD, 4'b0101);
    chk("read during write old", {32'd0, rd[0]}, 64'hFFFF_FFFF);
    rd_off(3'd2);
    chk("byte mask merge", {32'd0, rd[0]}, 64'hFFBB_FFDD);

    // Zero mask leaves msip alone
    wr(3'd4, 32'hFFFF_FFFF, 4'b0000);
    chk("mask0 no-op", {63'd0, si[0]}, 64'd0);

    // Count with carry into HI
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd0, 32'hFFFF_FFFE, 4'hF);
    chk("mtime after write", rt[0], 64'h0000_0000_FFFF_FFFE);
    idle();
    idle();
    chk("carry into hi", rt[0], 64'h0000_0001_0000_0000);

    // Full 64-bit wrap
    wr(3'd1, 32'hFFFF_FFFF, 4'hF);
    wr(3'd0, 32'hFFFF_FFFE, 4'hF);
    idle();
    idle();
    chk("64-bit wrap", rt[0], 64'd0);

    // Compare / interrupt level
    wr(3'd2, 32'd10, 4'hF);
    wr(3'd3, 32'd0, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd0, 32'd0, 4'hF);
    repeat (10) idle();
    chk("mtime reaches 10", rt[0], 64'd10);
    chk("t_irq not yet", {63'd0, ti[0]}, 64'd0);
    idle();
    chk("t_irq rises", {63'd0, ti[0]}, 64'd1);
    wr(3'd2, 32'd100, 4'hF);
    chk("t_irq holds one cycle", {63'd0, ti[0]}, 64'd1);
    idle();
    chk("t_irq falls", {63'd0, ti[0]}, 64'd0);

    // Write/tick collision on the divide-by-4 instance
    for (int i = 0; i < 4 && m_cnt[1] != 3; i++) idle();
    wr(3'd0, 32'h50, 4'hF);
    chk("collision lo div4", {32'd0, rt[1][31:0]}, 64'h50);
    chk("collision lo div1", {32'd0, rt[0][31:0]}, 64'h50);
    repeat (3) idle();
    chk("no tick before 4 cycles", {32'd0, rt[1][31:0]}, 64'h50);
    idle();
    chk("tick after 4 cycles", {32'd0, rt[1][31:0]}, 64'h51);

    // MSIP and address decode
    wr(3'd4, 32'hFFFF_FFFF, 4'hF);
    chk("s_irq set", {63'd0, si[0]}, 64'd1);
    rd_off(3'd4);
    chk("msip read", {32'd0, rd[0]}, 64'd1);
    cyc(BASE + 32'd32, 32'h1234_5678, 1'b1, 4'hF);
    chk("out-of-window read", {32'd0, rd[0]}, 64'd0);
    chk("s_irq after foreign write", {63'd0, si[1]}, 64'd1);
    wr(3'd5, 32'hFFFF_FFFF, 4'hF);
    rd_off(3'd5);
    chk("off5 reads zero", {32'd0, rd[0]}, 64'd0);
    wr(3'd4, 32'd0, 4'b0001);
    chk("s_irq cleared", {63'd0, si[1]}, 64'd0);
    repeat (3) idle();

    // Asynchronous reset in mid-cycle
    #3 RESET = 1'b1;
    #1 chk("async reset mtime", rt[1], 64'd0);
    chk("async reset cmp read", {32'd0, rd[0]}, 64'd0);
    @(negedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    rd_off(3'd3);
    chk("cmp_hi after reset", {32'd0, rd[1]}, 64'hFFFF_FFFF);
    idle();

    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
